// File: rtl/pipemem_access_if.sv
// Data-memory request/acknowledge bus between the MEM stage and a variable-latency memory.
// The MEM stage is the master: it drives request, strobe, address and write data.
interface pipemem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/pipemem_access.sv
// MEM stage with req/ack data-memory handshake, timeout abort, and the MEM/WB register.
// Optional stall performance counter enabled by defining PIPEMEM_STALL_CNT_EN.
module pipemem_access #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mwreg,
    input  logic                mm2reg,
    input  logic                mwmem,
    input  logic [31:0]         malu,
    input  logic [31:0]         mb,
    input  logic [4:0]          mrn,
    pipemem_access_if.master    dmem,
    output logic                mem_stall,
    output logic                wwreg,
    output logic                wm2reg,
    output logic [31:0]         wmo,
    output logic [31:0]         walu,
    output logic [4:0]          wrn,
    output logic                bus_err,
    output logic [31:0]         stall_cycles
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;

    logic             wwreg_q, wwreg_d;
    logic             wm2reg_q, wm2reg_d;
    logic [31:0]      wmo_q, wmo_d;
    logic [31:0]      walu_q, walu_d;
    logic [4:0]       wrn_q, wrn_d;

    logic             access;
    logic             is_load;
    logic             req;
    logic             done;
    logic             timeout_hit;
    logic             stall;

    // A store wins when both load and store flags are set.
    assign access      = mm2reg | mwmem;
    assign is_load     = mm2reg & ~mwmem;
    assign req         = ~reset & ((state_q == BUSY) | access);
    assign done        = req & dmem.dmem_ack;
    assign timeout_hit = (state_q == BUSY) & (cnt_q == TIMEOUT_C);
    assign stall       = req & ~dmem.dmem_ack & ~timeout_hit;

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = req & mwmem;
    assign dmem.dmem_addr  = malu;
    assign dmem.dmem_wdata = mb;

    assign mem_stall = stall;
    assign wwreg     = wwreg_q;
    assign wm2reg    = wm2reg_q;
    assign wmo       = wmo_q;
    assign walu      = walu_q;
    assign wrn       = wrn_q;
    assign bus_err   = bus_err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
        case (state_q)
            IDLE: begin
                if (access && !dmem.dmem_ack) begin
                    state_d = BUSY;
                    cnt_d   = CNT_ONE;
                end
            end
            BUSY: begin
                if (dmem.dmem_ack) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // MEM/WB: bubble while stalled or aborted; the data fields hold so WB sees stable values.
    always_comb begin
        wwreg_d  = wwreg_q;
        wm2reg_d = wm2reg_q;
        wmo_d    = wmo_q;
        walu_d   = walu_q;
        wrn_d    = wrn_q;
        if (stall || (timeout_hit && !dmem.dmem_ack)) begin
            wwreg_d  = 1'b0;
            wm2reg_d = 1'b0;
        end else if (done) begin
            wwreg_d  = mwreg;
            wm2reg_d = is_load;
            wmo_d    = is_load ? dmem.dmem_rdata : 32'd0;
            walu_d   = malu;
            wrn_d    = mrn;
        end else begin
            wwreg_d  = mwreg;
            wm2reg_d = 1'b0;
            wmo_d    = 32'd0;
            walu_d   = malu;
            wrn_d    = mrn;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wwreg_q  <= 1'b0;
            wm2reg_q <= 1'b0;
            wmo_q    <= 32'd0;
            walu_q   <= 32'd0;
            wrn_q    <= 5'd0;
        end else begin
            wwreg_q  <= wwreg_d;
            wm2reg_q <= wm2reg_d;
            wmo_q    <= wmo_d;
            walu_q   <= walu_d;
            wrn_q    <= wrn_d;
        end
    end

`ifdef PIPEMEM_STALL_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipemem_access.sv
// Directed bench for pipemem_access: single-cycle vector table plus multi-cycle stall,
// timeout, back-to-back and reset sequences (TIMEOUT set to 4).
module tb_pipemem_access;

    logic        clock;
    logic        reset;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic        mem_stall, wwreg, wm2reg, bus_err;
    logic [31:0] wmo, walu, stall_cycles;
    logic [4:0]  wrn;

    int errors = 0;
    int checks = 0;

    pipemem_access_if dmem_bus();

    pipemem_access #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .mwreg        (mwreg),
        .mm2reg       (mm2reg),
        .mwmem        (mwmem),
        .malu         (malu),
        .mb           (mb),
        .mrn          (mrn),
        .dmem         (dmem_bus),
        .mem_stall    (mem_stall),
        .wwreg        (wwreg),
        .wm2reg       (wm2reg),
        .wmo          (wmo),
        .walu         (walu),
        .wrn          (wrn),
        .bus_err      (bus_err),
        .stall_cycles (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wreg, m2reg, wmem;
        logic [31:0] alu, b;
        logic [4:0]  rn;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req, e_we;
        logic        e_wwreg, e_wm2reg;
        logic [31:0] e_wmo, e_walu;
        logic [4:0]  e_wrn;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic m2, input logic wm, input logic [31:0] alu,
                         input logic [31:0] b, input logic [4:0] rn, input logic ack,
                         input logic [31:0] rdata);
        mwreg  = wr;
        mm2reg = m2;
        mwmem  = wm;
        malu   = alu;
        mb     = b;
        mrn    = rn;
        dmem_bus.dmem_ack   = ack;
        dmem_bus.dmem_rdata = rdata;
    endtask

    function automatic logic [31:0] exp_stalls(input logic [31:0] n);
`ifdef PIPEMEM_STALL_CNT_EN
        return n;
`else
        return 32'd0 & n;
`endif
    endfunction

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1,0,0, 32'h1234, 32'h0, 5'd8, 0, 32'h0,        0,0, 1,0, 32'h0,        32'h1234, 5'd8};
        vecs[1] = '{1,1,0, 32'h40,   32'h0, 5'd3, 1, 32'hDEADBEEF, 1,0, 1,1, 32'hDEADBEEF, 32'h40,   5'd3};
        vecs[2] = '{0,0,0, 32'h5,    32'h0, 5'd1, 0, 32'h0,        0,0, 0,0, 32'h0,        32'h5,    5'd1};
        vecs[3] = '{0,0,1, 32'h80,   32'h55,5'd0, 1, 32'h12345678, 1,1, 0,0, 32'h0,        32'h80,   5'd0};
        vecs[4] = '{1,1,1, 32'hC,    32'h77,5'd9, 1, 32'hAAAA5555, 1,1, 1,0, 32'h0,        32'hC,    5'd9};
        vecs[5] = '{0,0,0, 32'h99,   32'h0, 5'd31,1, 32'hFFFFFFFF, 0,0, 0,0, 32'h0,        32'h99,   5'd31};

        reset = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        #1;
        chk("rst_req",    dmem_bus.dmem_req, 0);
        chk("rst_wwreg",  wwreg, 0);
        chk("rst_wm2reg", wm2reg, 0);
        chk("rst_wmo",    wmo, 0);
        chk("rst_walu",   walu, 0);
        chk("rst_wrn",    wrn, 0);
        chk("rst_buserr", bus_err, 0);
        chk("rst_stallc", stall_cycles, 0);
        @(negedge clock);
        reset = 1'b0;

        // Single-cycle transactions: non-memory ops and zero-wait accesses.
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            drive(vecs[i].wreg, vecs[i].m2reg, vecs[i].wmem, vecs[i].alu, vecs[i].b,
                  vecs[i].rn, vecs[i].ack, vecs[i].rdata);
            #1;
            chk($sformatf("v%0d_req", i),   dmem_bus.dmem_req, vecs[i].e_req);
            chk($sformatf("v%0d_we", i),    dmem_bus.dmem_we, vecs[i].e_we);
            chk($sformatf("v%0d_stall", i), mem_stall, 0);
            chk($sformatf("v%0d_addr", i),  dmem_bus.dmem_addr, vecs[i].alu);
            chk($sformatf("v%0d_wdata", i), dmem_bus.dmem_wdata, vecs[i].b);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_wwreg", i),  wwreg, vecs[i].e_wwreg);
            chk($sformatf("v%0d_wm2reg", i), wm2reg, vecs[i].e_wm2reg);
            chk($sformatf("v%0d_wmo", i),    wmo, vecs[i].e_wmo);
            chk($sformatf("v%0d_walu", i),   walu, vecs[i].e_walu);
            chk($sformatf("v%0d_wrn", i),    wrn, vecs[i].e_wrn);
        end

        // Store acknowledged on the fourth request cycle: three stall cycles.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i == 0) drive(1, 0, 1, 32'h80, 32'h55, 5'd4, 0, 32'h0);
            if (i == 3) dmem_bus.dmem_ack = 1'b1;
            #1;
            chk($sformatf("st%0d_req", i),   dmem_bus.dmem_req, 1);
            chk($sformatf("st%0d_we", i),    dmem_bus.dmem_we, 1);
            chk($sformatf("st%0d_addr", i),  dmem_bus.dmem_addr, 32'h80);
            chk($sformatf("st%0d_wdata", i), dmem_bus.dmem_wdata, 32'h55);
            chk($sformatf("st%0d_stall", i), mem_stall, (i < 3) ? 1 : 0);
            @(posedge clock);
            #1;
            if (i < 3) begin
                chk($sformatf("st%0d_bubble", i), wwreg, 0);
                chk($sformatf("st%0d_walu_hold", i), walu, 32'h99);
            end else begin
                chk("st_wwreg", wwreg, 1);
                chk("st_wm2reg", wm2reg, 0);
                chk("st_walu", walu, 32'h80);
                chk("st_wrn", wrn, 5'd4);
                chk("st_wmo", wmo, 0);
            end
        end
        chk("st_stall_cycles", stall_cycles, exp_stalls(32'd3));

        // Load never acknowledged: aborts once the counter reaches 4.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i == 0) drive(1, 1, 0, 32'h100, 32'h0, 5'd6, 0, 32'h0);
            #1;
            chk($sformatf("to%0d_req", i),   dmem_bus.dmem_req, 1);
            chk($sformatf("to%0d_stall", i), mem_stall, (i < 4) ? 1 : 0);
            @(posedge clock);
            #1;
            chk($sformatf("to%0d_wwreg", i),  wwreg, 0);
            chk($sformatf("to%0d_buserr", i), bus_err, (i < 4) ? 0 : 1);
        end
        chk("to_wm2reg", wm2reg, 0);
        @(negedge clock);
        drive(1, 0, 0, 32'h200, 32'h0, 5'd7, 0, 32'h0);
        #1;
        chk("to_alu_req", dmem_bus.dmem_req, 0);
        chk("to_alu_stall", mem_stall, 0);
        @(posedge clock);
        #1;
        chk("to_alu_wwreg", wwreg, 1);
        chk("to_alu_walu", walu, 32'h200);
        chk("to_alu_wrn", wrn, 5'd7);
        chk("to_buserr_sticky", bus_err, 1);
        chk("to_stall_cycles", stall_cycles, exp_stalls(32'd7));

        // Back-to-back loads, each acknowledged after one wait cycle.
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            case (c)
                0: drive(1, 1, 0, 32'h300, 32'h0, 5'd10, 0, 32'h0);
                1: begin dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hA1A1A1A1; end
                2: drive(1, 1, 0, 32'h304, 32'h0, 5'd11, 0, 32'h0);
                default: begin dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hB2B2B2B2; end
            endcase
            #1;
            chk($sformatf("bb%0d_req", c),   dmem_bus.dmem_req, 1);
            chk($sformatf("bb%0d_stall", c), mem_stall, (c == 0 || c == 2) ? 1 : 0);
            @(posedge clock);
            #1;
            case (c)
                0: chk("bb0_bubble", wwreg, 0);
                1: begin
                    chk("bb1_wmo", wmo, 32'hA1A1A1A1);
                    chk("bb1_wrn", wrn, 5'd10);
                    chk("bb1_wm2reg", wm2reg, 1);
                    chk("bb1_wwreg", wwreg, 1);
                end
                2: begin
                    chk("bb2_bubble", wwreg, 0);
                    chk("bb2_wmo_hold", wmo, 32'hA1A1A1A1);
                end
                default: begin
                    chk("bb3_wmo", wmo, 32'hB2B2B2B2);
                    chk("bb3_wrn", wrn, 5'd11);
                    chk("bb3_walu", walu, 32'h304);
                end
            endcase
        end
        chk("bb_stall_cycles", stall_cycles, exp_stalls(32'd9));

        // Reset while a load is waiting in BUSY.
        @(negedge clock);
        drive(1, 1, 0, 32'h400, 32'h0, 5'd12, 0, 32'h0);
        @(negedge clock);
        #1;
        chk("mr_busy_stall", mem_stall, 1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mr_req", dmem_bus.dmem_req, 0);
        chk("mr_stall", mem_stall, 0);
        chk("mr_wwreg", wwreg, 0);
        chk("mr_walu", walu, 0);
        chk("mr_wmo", wmo, 0);
        chk("mr_wrn", wrn, 0);
        chk("mr_buserr", bus_err, 0);
        chk("mr_stallc", stall_cycles, 0);
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mr_post_req", dmem_bus.dmem_req, 0);
        chk("mr_post_stall", mem_stall, 0);
        @(posedge clock);
        #1;
        chk("mr_post_req2", dmem_bus.dmem_req, 0);
        chk("mr_post_wwreg", wwreg, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
